item_memory_arbiter: RTL and testbench

- Shares one item_memory instance between two requesters: the encoder datapath (req0) and the host/debug readback path (req1).
- Arbitrates address requests round-robin and drives the item memory's port-A mode select and its A/B addresses.
- Captures the combinational hypervector outputs into a single-entry response register.
- Returns data on one tagged valid/ready response channel with full backpressure.

---
 rtl/item_memory_arbiter.sv | 83 ++++++++
 tb/tb_item_memory_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/item_memory_arbiter.sv
// Round-robin arbiter sharing one item_memory between two requesters, with a
// single-entry registered response buffer on a tagged valid/ready channel.
module item_memory_arbiter #(
   parameter int HVDimension = 512,
   parameter int NumTotIm    = 1024,
   parameter int ImAddrWidth = $clog2(NumTotIm)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   req0_valid_i,
   output logic                   req0_ready_o,
   input  logic                   req0_cim_i,
   input  logic [ImAddrWidth-1:0] req0_a_addr_i,
   input  logic [ImAddrWidth-1:0] req0_b_addr_i,
   input  logic                   req1_valid_i,
   output logic                   req1_ready_o,
   input  logic                   req1_cim_i,
   input  logic [ImAddrWidth-1:0] req1_a_addr_i,
   input  logic [ImAddrWidth-1:0] req1_b_addr_i,
   output logic                   im_port_a_cim_o,
   output logic [ImAddrWidth-1:0] im_a_addr_o,
   output logic [ImAddrWidth-1:0] im_b_addr_o,
   input  logic [HVDimension-1:0] im_a_i,
   input  logic [HVDimension-1:0] im_b_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic                   rsp_id_o,
   output logic [HVDimension-1:0] rsp_a_o,
   output logic [HVDimension-1:0] rsp_b_o
);

   logic r_last_grant;
   logic w_grant0;
   logic w_grant1;
   logic w_can_accept;
   logic w_fire;

   // Single-entry buffer: may drain and refill in the same cycle.
   assign w_can_accept = ~rsp_valid_o | rsp_ready_i;

   // Under contention the requester that did not win last time is granted.
   assign w_grant0 = req0_valid_i & (~req1_valid_i | r_last_grant);
   assign w_grant1 = req1_valid_i & (~req0_valid_i | ~r_last_grant);

   assign req0_ready_o = w_grant0 & w_can_accept;
   assign req1_ready_o = w_grant1 & w_can_accept;
   assign w_fire       = (w_grant0 | w_grant1) & w_can_accept;

   // Memory addresses follow the grant alone so they stay stable under backpressure.
   always_comb begin
      im_port_a_cim_o = 1'b0;
      im_a_addr_o     = '0;
      im_b_addr_o     = '0;
      if (w_grant0) begin
         im_port_a_cim_o = req0_cim_i;
         im_a_addr_o     = req0_a_addr_i;
         im_b_addr_o     = req0_b_addr_i;
      end else if (w_grant1) begin
         im_port_a_cim_o = req1_cim_i;
         im_a_addr_o     = req1_a_addr_i;
         im_b_addr_o     = req1_b_addr_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_o  <= 1'b0;
         rsp_id_o     <= 1'b0;
         rsp_a_o      <= '0;
         rsp_b_o      <= '0;
         r_last_grant <= 1'b1;
      end else if (w_fire) begin
         rsp_valid_o  <= 1'b1;
         rsp_id_o     <= w_grant1;
         rsp_a_o      <= im_a_i;
         rsp_b_o      <= im_b_i;
         r_last_grant <= w_grant1;
      end else if (rsp_ready_i) begin
         rsp_valid_o  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_item_memory_arbiter.sv
// Bench for item_memory_arbiter: table of per-cycle vectors plus a reset-mid-operation sequence.
module tb_item_memory_arbiter;
   localparam int HV = 512;
   localparam int AW = 10;

   logic          clk;
   logic          rst_n;
   logic          v0, c0, v1, c1, rr;
   logic [AW-1:0] a0, b0, a1, b1;
   logic          r0, r1, im_cim;
   logic [AW-1:0] im_a_addr, im_b_addr;
   logic [HV-1:0] im_a, im_b;
   logic          rsp_v, rsp_id;
   logic [HV-1:0] rsp_a, rsp_b;

   int n_checks = 0;
   int n_errors = 0;

   item_memory_arbiter #(.HVDimension(HV), .NumTotIm(1024)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req0_valid_i(v0), .req0_ready_o(r0), .req0_cim_i(c0),
      .req0_a_addr_i(a0), .req0_b_addr_i(b0),
      .req1_valid_i(v1), .req1_ready_o(r1), .req1_cim_i(c1),
      .req1_a_addr_i(a1), .req1_b_addr_i(b1),
      .im_port_a_cim_o(im_cim), .im_a_addr_o(im_a_addr), .im_b_addr_o(im_b_addr),
      .im_a_i(im_a), .im_b_i(im_b),
      .rsp_valid_o(rsp_v), .rsp_ready_i(rr), .rsp_id_o(rsp_id),
      .rsp_a_o(rsp_a), .rsp_b_o(rsp_b)
   );

   function automatic logic [HV-1:0] hv(input logic [AW-1:0] addr, input logic cim,
                                        input logic port);
      logic [HV-1:0] res;
      logic [31:0]   w;
      w = {port, cim, 20'h5A5A5, addr};
      for (int i = 0; i < HV / 32; i++) res[i*32 +: 32] = (w ^ 32'hC3A50F96) + i;
      return res;
   endfunction

   // Combinational item memory stand-in.
   assign im_a = hv(im_a_addr, im_cim, 1'b0);
   assign im_b = hv(im_b_addr, 1'b0, 1'b1);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [HV-1:0] act, input logic [HV-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic v0, c0; logic [AW-1:0] a0, b0;
      logic v1, c1; logic [AW-1:0] a1, b1;
      logic rr;
      logic e_r0, e_r1, e_cim; logic [AW-1:0] e_ia, e_ib;
      logic e_v, e_id, e_dc; logic [AW-1:0] e_da, e_db;
   } vec_t;

   vec_t vecs[16];

   task automatic drive(input logic iv0, input logic ic0, input logic [AW-1:0] ia0,
                        input logic [AW-1:0] ib0, input logic iv1, input logic ic1,
                        input logic [AW-1:0] ia1, input logic [AW-1:0] ib1, input logic irr);
      v0 = iv0; c0 = ic0; a0 = ia0; b0 = ib0;
      v1 = iv1; c1 = ic1; a1 = ia1; b1 = ib1;
      rr = irr;
   endtask

   initial begin
      // Contention pair used repeatedly: req0 {cim0,1,2}, req1 {cim0,3,4}.
      vecs[0]  = '{1'b1,1'b0,10'd5,10'd9, 1'b0,1'b0,10'd0,10'd0, 1'b1,
                   1'b1,1'b0,1'b0,10'd5,10'd9, 1'b1,1'b0,1'b0,10'd5,10'd9};
      vecs[1]  = '{1'b1,1'b0,10'd1,10'd2, 1'b1,1'b0,10'd3,10'd4, 1'b1,
                   1'b0,1'b1,1'b0,10'd3,10'd4, 1'b1,1'b1,1'b0,10'd3,10'd4};
      vecs[2]  = '{1'b1,1'b0,10'd1,10'd2, 1'b1,1'b0,10'd3,10'd4, 1'b1,
                   1'b1,1'b0,1'b0,10'd1,10'd2, 1'b1,1'b0,1'b0,10'd1,10'd2};
      vecs[3]  = vecs[1];
      vecs[4]  = vecs[2];
      vecs[5]  = vecs[1];
      vecs[6]  = vecs[2];
      vecs[7]  = '{1'b0,1'b0,10'd0,10'd0, 1'b1,1'b1,10'd17,10'd20, 1'b0,
                   1'b0,1'b0,1'b1,10'd17,10'd20, 1'b1,1'b0,1'b0,10'd1,10'd2};
      vecs[8]  = vecs[7];
      vecs[9]  = vecs[7];
      vecs[10] = vecs[7];
      vecs[11] = '{1'b0,1'b0,10'd0,10'd0, 1'b1,1'b1,10'd17,10'd20, 1'b1,
                   1'b0,1'b1,1'b1,10'd17,10'd20, 1'b1,1'b1,1'b1,10'd17,10'd20};
      vecs[12] = '{1'b1,1'b0,10'd7,10'd8, 1'b0,1'b0,10'd0,10'd0, 1'b1,
                   1'b1,1'b0,1'b0,10'd7,10'd8, 1'b1,1'b0,1'b0,10'd7,10'd8};
      vecs[13] = '{1'b0,1'b0,10'd0,10'd0, 1'b0,1'b0,10'd0,10'd0, 1'b0,
                   1'b0,1'b0,1'b0,10'd0,10'd0, 1'b1,1'b0,1'b0,10'd7,10'd8};
      vecs[14] = '{1'b0,1'b0,10'd0,10'd0, 1'b0,1'b0,10'd0,10'd0, 1'b1,
                   1'b0,1'b0,1'b0,10'd0,10'd0, 1'b0,1'b0,1'b0,10'd7,10'd8};
      vecs[15] = vecs[14];

      rst_n = 1'b0;
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_valid", HV'(rsp_v), HV'(1'b0));
      check("reset_id", HV'(rsp_id), HV'(1'b0));
      check("reset_a", rsp_a, '0);
      check("reset_b", rsp_b, '0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(vecs[i].v0, vecs[i].c0, vecs[i].a0, vecs[i].b0,
               vecs[i].v1, vecs[i].c1, vecs[i].a1, vecs[i].b1, vecs[i].rr);
         #1;
         check($sformatf("v%0d_ready0", i), HV'(r0), HV'(vecs[i].e_r0));
         check($sformatf("v%0d_ready1", i), HV'(r1), HV'(vecs[i].e_r1));
         check($sformatf("v%0d_im_cim", i), HV'(im_cim), HV'(vecs[i].e_cim));
         check($sformatf("v%0d_im_a_addr", i), HV'(im_a_addr), HV'(vecs[i].e_ia));
         check($sformatf("v%0d_im_b_addr", i), HV'(im_b_addr), HV'(vecs[i].e_ib));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_rsp_valid", i), HV'(rsp_v), HV'(vecs[i].e_v));
         check($sformatf("v%0d_rsp_id", i), HV'(rsp_id), HV'(vecs[i].e_id));
         check($sformatf("v%0d_rsp_a", i), rsp_a, hv(vecs[i].e_da, vecs[i].e_dc, 1'b0));
         check($sformatf("v%0d_rsp_b", i), rsp_b, hv(vecs[i].e_db, 1'b0, 1'b1));
      end

      // Reset while a response is held under backpressure.
      @(negedge clk);
      drive(1'b1, 1'b0, 10'd3, 10'd6, 1'b1, 1'b1, 10'd11, 10'd12, 1'b0);
      @(posedge clk);
      #1;
      check("pre_rst_valid", HV'(rsp_v), HV'(1'b1));
      check("pre_rst_id", HV'(rsp_id), HV'(1'b1));
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", HV'(rsp_v), HV'(1'b0));
      check("mid_rst_id", HV'(rsp_id), HV'(1'b0));
      check("mid_rst_a", rsp_a, '0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_ready0", HV'(r0), HV'(1'b1));
      check("post_rst_ready1", HV'(r1), HV'(1'b0));
      check("post_rst_im_a", HV'(im_a_addr), HV'(10'd3));
      @(posedge clk);
      #1;
      check("post_rst_valid", HV'(rsp_v), HV'(1'b1));
      check("post_rst_id", HV'(rsp_id), HV'(1'b0));
      check("post_rst_a", rsp_a, hv(10'd3, 1'b0, 1'b0));
      check("post_rst_b", rsp_b, hv(10'd6, 1'b0, 1'b1));
      @(negedge clk);
      rr = 1'b1;
      #1;
      check("post_rst2_ready1", HV'(r1), HV'(1'b1));
      @(posedge clk);
      #1;
      check("post_rst2_id", HV'(rsp_id), HV'(1'b1));
      check("post_rst2_a", rsp_a, hv(10'd11, 1'b1, 1'b0));
      check("post_rst2_b", rsp_b, hv(10'd12, 1'b0, 1'b1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
